// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the fetch front end: XLEN, instruction field
// positions, fetch FSM state encoding, fetch buffer entry and default reset PC.
package rv32_pkg;

    localparam int XLEN         = 32;

    localparam int OPCODE_LSB   = 0;
    localparam int OPCODE_MSB   = 6;
    localparam int FUNCT3_LSB   = 12;
    localparam int FUNCT3_MSB   = 14;
    localparam int FUNCT7_5_BIT = 30;

    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_RESET_WAIT = 2'd0,
        ST_FETCH      = 2'd1,
        ST_FLUSH      = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// In-order fetch buffer. A slot is allocated (pc known, data empty) when a
// request is issued and filled when its response returns; the head pops only
// once filled. Three pointers: head (pop), fill (oldest unfilled), tail (alloc).
module fetch_buffer
    import rv32_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             alloc,
    input  logic [XLEN-1:0]  alloc_pc,
    input  logic             fill,
    input  logic [XLEN-1:0]  fill_instr,
    input  logic             pop,
    output logic             head_valid,
    output logic [XLEN-1:0]  head_pc,
    output logic [XLEN-1:0]  head_instr,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] unfilled
);

    localparam int IDX_W = CNT_W - 1;

    fetch_entry_t     slot_q [DEPTH];
    fetch_entry_t     slot_d [DEPTH];
    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] tail_q, tail_d;

    logic [IDX_W-1:0] head_idx, fill_idx, tail_idx;

    assign head_idx   = head_q[IDX_W-1:0];
    assign fill_idx   = fill_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];

    assign count      = tail_q - head_q;
    assign unfilled   = tail_q - fill_q;
    assign head_valid = (count != '0) && slot_q[head_idx].filled;
    assign head_pc    = slot_q[head_idx].pc;
    assign head_instr = slot_q[head_idx].instr;

    // Next slot contents and pointers; clear overrides every other operation.
    always_comb begin
        slot_d = slot_q;
        head_d = head_q;
        fill_d = fill_q;
        tail_d = tail_q;
        if (clear) begin
            head_d = '0;
            fill_d = '0;
            tail_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_d[i].filled = 1'b0;
            end
        end else begin
            if (alloc) begin
                slot_d[tail_idx].pc     = alloc_pc;
                slot_d[tail_idx].instr  = '0;
                slot_d[tail_idx].filled = 1'b0;
                tail_d = tail_q + CNT_W'(1);
            end
            if (fill) begin
                slot_d[fill_idx].instr  = fill_instr;
                slot_d[fill_idx].filled = 1'b1;
                fill_d = fill_q + CNT_W'(1);
            end
            if (pop) begin
                head_d = head_q + CNT_W'(1);
            end
        end
    end

    // Slot storage and pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
            head_q <= '0;
            fill_q <= '0;
            tail_q <= '0;
        end else begin
            slot_q <= slot_d;
            head_q <= head_d;
            fill_q <= fill_d;
            tail_q <= tail_d;
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch unit: issues in-order instruction-memory requests, buffers
// responses in fetch_buffer, and discards stale responses after a redirect.
// Optional macro INSTRUCTION_FETCH_MISALIGN_EN adds a sticky misalign output
// that halts fetch on a misaligned redirect target; without it the target's
// low two bits are forced to zero.
module instruction_fetch
    import rv32_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_plus4,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic            out_funct7_5
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    ,
    output logic            misalign
`endif
);

    localparam int               CNT_W   = $clog2(BUF_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [CNT_W-1:0] drop_q, drop_d;

    logic             req_fire, rsp_beat, pop, fill;
    logic             fetch_block;
    logic [XLEN-1:0]  target_pc;
    logic [CNT_W-1:0] buf_count, buf_unfilled, outstanding;

`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    logic misalign_q, misalign_d;
    assign fetch_block = misalign_q;
    assign target_pc   = redirect_pc;
    assign misalign    = misalign_q;
`else
    assign fetch_block = 1'b0;
    assign target_pc   = redirect_pc & ~32'h3;
`endif

    // In FLUSH the buffer is empty, so outstanding beats live in the drop counter.
    assign outstanding    = (state_q == ST_FLUSH) ? drop_q : buf_unfilled;
    assign imem_req_valid = (state_q == ST_FETCH) && (buf_count < DEPTH_C) && !fetch_block;
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_beat       = imem_rsp_valid && (outstanding != '0);
    assign fill           = rsp_beat && (state_q == ST_FETCH) && !redirect_valid;
    assign pop            = out_valid && out_ready && !redirect_valid;

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .CNT_W (CNT_W)
    ) u_buf (
        .clk        (clk),
        .rst        (rst),
        .clear      (redirect_valid),
        .alloc      (req_fire && !redirect_valid),
        .alloc_pc   (pc_q),
        .fill       (fill),
        .fill_instr (imem_rsp_data),
        .pop        (pop),
        .head_valid (out_valid),
        .head_pc    (out_pc),
        .head_instr (out_instr),
        .count      (buf_count),
        .unfilled   (buf_unfilled)
    );

    assign out_pc_plus4 = out_pc + 32'd4;
    assign out_opcode   = out_instr[OPCODE_MSB:OPCODE_LSB];
    assign out_funct3   = out_instr[FUNCT3_MSB:FUNCT3_LSB];
    assign out_funct7_5 = out_instr[FUNCT7_5_BIT];

    // Next FSM state, fetch PC and drop count; a redirect overrides everything.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        misalign_d = misalign_q;
`endif
        case (state_q)
            ST_RESET_WAIT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (req_fire) pc_d = pc_q + 32'd4;
            end
            ST_FLUSH: begin
                if (rsp_beat) drop_d = drop_q - CNT_W'(1);
                if (drop_d == '0) state_d = ST_FETCH;
            end
            default: state_d = ST_RESET_WAIT;
        endcase
        if (redirect_valid) begin
            pc_d    = target_pc;
            drop_d  = outstanding - CNT_W'(rsp_beat) + CNT_W'(req_fire);
            state_d = (drop_d != '0) ? ST_FLUSH : ST_FETCH;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
            misalign_d = |redirect_pc[1:0];
`endif
        end
    end

    // FSM and fetch-control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RESET_WAIT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
            misalign_q <= misalign_d;
`endif
        end
    end

    // A response beat with no request behind it means the memory side overran us.
    rsp_has_slot: assert property (@(posedge clk) disable iff (rst)
        imem_rsp_valid |-> (outstanding != '0));

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid, out_ready;
    logic [31:0] out_instr, out_pc, out_pc_plus4;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic        out_funct7_5;
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
    logic        misalign;
`endif

    instruction_fetch #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_pc_plus4   (out_pc_plus4),
        .out_opcode     (out_opcode),
        .out_funct3     (out_funct3),
        .out_funct7_5   (out_funct7_5)
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        ,
        .misalign       (misalign)
`endif
    );

    always #5 clk = ~clk;

    // bench state: stimulus knobs, memory model, program-order reference
    int          n_checks = 0, n_errors = 0;
    int          cyc = 0;
    logic        rdy, ordy, redir;
    logic [31:0] redir_pc;
    int          lat_min, lat_max;
    logic [31:0] mq_addr[$];
    int          mq_due[$];
    int          last_due;
    int          stale_cnt, buffered;
    logic [31:0] exp_req, exp_out;
    int          n_fire = 0, n_pop = 0, n_rsp = 0;
    bit          busy_redirect, did_redirect, saw_zero_req;
    bit          prev_hold;
    logic [31:0] prev_pc, prev_instr;
    bit          mis_m;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // One clock cycle: drive at negedge, observe 1ns later, advance reference model.
    task automatic step();
        bit          rsp_now, fire, pop, do_redir;
        logic [31:0] ei, tgt;
        int          due;
        @(negedge clk);
        rsp_now        = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
        imem_rsp_valid = rsp_now;
        imem_rsp_data  = rsp_now ? mem_word(mq_addr[0]) : 32'h0;
        imem_req_ready = rdy;
        out_ready      = ordy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        #1;
        do_redir = redir;
        if (busy_redirect && !redir && out_valid && imem_req_valid && out_ready && imem_req_ready) begin
            redirect_valid = 1'b1;
            do_redir       = 1'b1;
            did_redirect   = 1'b1;
            #1;
        end
        check_val("out_valid", out_valid, buffered > 0);
        if (prev_hold) begin
            check_val("hold_pc", out_pc, prev_pc);
            check_val("hold_instr", out_instr, prev_instr);
        end
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        check_val("misalign", misalign, mis_m);
`endif
        fire = imem_req_valid && imem_req_ready;
        pop  = out_valid && out_ready;
        if (fire) begin
            check_val("req_addr", imem_req_addr, exp_req);
            check_val("req_in_flush", stale_cnt, 0);
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
            check_val("req_while_misaligned", mis_m, 0);
`endif
            if (imem_req_addr == 32'h0) saw_zero_req = 1'b1;
            due = cyc + $urandom_range(lat_max, lat_min);
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mq_addr.push_back(imem_req_addr);
            mq_due.push_back(due);
            n_fire++;
        end
        if (pop && !do_redir) begin
            ei = mem_word(exp_out);
            check_val("out_pc", out_pc, exp_out);
            check_val("out_instr", out_instr, ei);
            check_val("out_pc_plus4", out_pc_plus4, exp_out + 32'd4);
            check_val("out_opcode", out_opcode, ei[6:0]);
            check_val("out_funct3", out_funct3, ei[14:12]);
            check_val("out_funct7_5", out_funct7_5, ei[30]);
            exp_out = exp_out + 32'd4;
            buffered--;
            n_pop++;
        end
        if (rsp_now) begin
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
            n_rsp++;
            if (!do_redir) begin
                if (stale_cnt > 0) stale_cnt--;
                else buffered++;
            end
        end
        if (fire && !do_redir) exp_req = exp_req + 32'd4;
        if (do_redir) begin
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
            tgt   = redirect_pc;
            mis_m = |redirect_pc[1:0];
`else
            tgt   = redirect_pc & ~32'h3;
`endif
            stale_cnt = mq_addr.size();
            buffered  = 0;
            exp_req   = tgt;
            exp_out   = tgt;
        end
        check_val("occupancy_le_depth", ((mq_addr.size() - stale_cnt) + buffered) <= DEPTH, 1);
        prev_hold  = out_valid && !out_ready && !do_redir;
        prev_pc    = out_pc;
        prev_instr = out_instr;
        @(posedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_req_ready = 1'b0; out_ready = 1'b0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        rdy = 1'b0; ordy = 1'b0; redir = 1'b0; redir_pc = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mq_addr.delete(); mq_due.delete();
        last_due = cyc; stale_cnt = 0; buffered = 0;
        exp_req = RPC; exp_out = RPC; mis_m = 1'b0; prev_hold = 1'b0;
        #1;
        check_val("rst_req_valid", imem_req_valid, 0);
        check_val("rst_out_valid", out_valid, 0);
`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        check_val("rst_misalign", misalign, 0);
`endif
        @(posedge clk);
        cyc++;
    endtask

    task automatic wait_idle();
        bit idle;
        rdy = 1'b0; ordy = 1'b1; redir = 1'b0;
        idle = 1'b0;
        for (int i = 0; i < 60 && !idle; i++) begin
            step();
            idle = (mq_addr.size() == 0) && (buffered == 0);
        end
        check_val("drain_timeout", idle, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int f0, r0, p0;
        bit done;
        busy_redirect = 1'b0; did_redirect = 1'b0; saw_zero_req = 1'b0;
        lat_min = 1; lat_max = 1;
        do_reset();

        // sequential fetch from RESET_PC, 1-cycle memory, full throughput
        rdy = 1'b1; ordy = 1'b1;
        repeat (5) step();
        p0 = n_pop;
        repeat (20) step();
        check_val("throughput", n_pop - p0, 20);

        // decoder stall for 5 cycles
        ordy = 1'b0;
        f0 = n_fire;
        repeat (5) step();
        check_val("stall_fires_bound", (n_fire - f0) <= DEPTH, 1);
        ordy = 1'b1;
        repeat (10) step();

        // 3-cycle memory, 2 outstanding, redirect to 0x200
        wait_idle();
        lat_min = 3; lat_max = 3;
        rdy = 1'b1; ordy = 1'b1;
        f0 = n_fire;
        repeat (2) step();
        check_val("two_outstanding", n_fire - f0, 2);
        rdy = 1'b0; redir = 1'b1; redir_pc = 32'h200;
        r0 = n_rsp; f0 = n_fire;
        step();
        redir = 1'b0; rdy = 1'b1;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            done = (n_fire > f0);
        end
        check_val("flush_resume_timeout", done, 1);
        check_val("dropped_rsps", n_rsp - r0, 2);
        p0 = n_pop;
        for (int i = 0; i < 30 && n_pop == p0; i++) step();
        check_val("resume_pop_seen", n_pop > p0, 1);

        // redirect coinciding with a request fire and a pop
        lat_min = 1; lat_max = 1;
        repeat (8) step();
        redir_pc = 32'h400; busy_redirect = 1'b1; did_redirect = 1'b0;
        for (int i = 0; i < 20 && !did_redirect; i++) step();
        busy_redirect = 1'b0;
        check_val("busy_redirect_seen", did_redirect, 1);
        repeat (10) step();

        // PC wrap at the top of the address space
        redir = 1'b1; redir_pc = 32'hFFFF_FFF0;
        step();
        redir = 1'b0;
        repeat (12) step();
        check_val("wrap_to_zero", saw_zero_req, 1);

`ifdef INSTRUCTION_FETCH_MISALIGN_EN
        // misaligned redirect halts fetch until an aligned one
        wait_idle();
        rdy = 1'b1; ordy = 1'b1;
        redir = 1'b1; redir_pc = 32'h202;
        step();
        redir = 1'b0;
        f0 = n_fire;
        repeat (10) step();
        check_val("misalign_no_req", n_fire - f0, 0);
        check_val("misalign_set", misalign, 1);
        redir = 1'b1; redir_pc = 32'h300;
        step();
        redir = 1'b0;
        check_val("misalign_clear", misalign, 0);
        f0 = n_fire;
        repeat (6) step();
        check_val("fetch_after_aligned", n_fire > f0, 1);
`else
        // misaligned target is forced down to a word boundary
        lat_min = 2; lat_max = 2;
        rdy = 1'b1; ordy = 1'b1;
        redir = 1'b1; redir_pc = 32'h0000_0203;
        step();
        redir = 1'b0;
        p0 = n_pop;
        repeat (12) step();
        check_val("forced_align_pops", n_pop > p0, 1);
`endif

        // randomized traffic with occasional redirects
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 400; i++) begin
            rdy      = ($urandom_range(3, 0) != 0);
            ordy     = ($urandom_range(9, 0) < 7);
            redir    = ($urandom_range(31, 0) == 0);
            redir_pc = $urandom;
            step();
        end
        redir = 1'b0;
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
